// File: rtl/riscv_v_elastic_stage.sv
// Multi-stage elastic register pipeline with valid/ready flow control.
// Invalid stages always accept from their predecessor, so bubbles collapse under back-pressure.
// Also provides a synchronous flush and occupancy reporting.
module riscv_v_elastic_stage #(
  parameter int DATA_W     = 9,
  parameter int NUM_STAGES = 2,
  localparam int CNT_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rst_val_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  occupancy_o,
  output logic              empty_o,
  output logic              full_o
);

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("NUM_STAGES must lie in 1..16");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("DATA_W must be at least 1");
  end

  // Stage state, indexed 1..NUM_STAGES with NUM_STAGES nearest the output.
  logic [NUM_STAGES:1] vld_q, vld_d;
  logic [DATA_W-1:0]   dat_q [NUM_STAGES:1];
  logic [DATA_W-1:0]   dat_d [NUM_STAGES:1];

  // rdy[i]: stage i may load this cycle.
  logic [NUM_STAGES:1] rdy;

  // Source of each stage: index 0 is the input port, index i is stage i.
  logic [NUM_STAGES-1:0] v_src;
  logic [DATA_W-1:0]     d_src [NUM_STAGES-1:0];

  // Ready chain from the output back to the input; an empty stage is always ready.
  always_comb begin
    logic carry;
    carry = out_ready_i;
    for (int i = NUM_STAGES; i >= 1; i--) begin
      rdy[i] = ~vld_q[i] | carry;
      carry  = rdy[i];
    end
  end

  assign in_ready_o = rdy[1] & ~flush_i & ~rst;

  // Gather stage sources so stage i always reads from index i-1.
  always_comb begin
    v_src[0] = in_valid_i & in_ready_o;
    d_src[0] = in_data_i;
    for (int i = 1; i < NUM_STAGES; i++) begin
      v_src[i] = vld_q[i];
      d_src[i] = dat_q[i];
    end
  end

  // Next-state: flush clears everything, otherwise ready stages shift forward.
  always_comb begin
    vld_d = vld_q;
    for (int i = 1; i <= NUM_STAGES; i++) begin
      dat_d[i] = dat_q[i];
    end
    if (flush_i) begin
      vld_d = '0;
      for (int i = 1; i <= NUM_STAGES; i++) begin
        dat_d[i] = rst_val_i;
      end
    end else begin
      for (int i = 1; i <= NUM_STAGES; i++) begin
        if (rdy[i]) begin
          vld_d[i] = v_src[i-1];
          // A bubble moving in leaves the old payload in place.
          if (v_src[i-1]) begin
            dat_d[i] = d_src[i-1];
          end
        end
      end
    end
  end

  // Stage registers; reset loads the run-time reset value into every data slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 1; i <= NUM_STAGES; i++) begin
        dat_q[i] <= rst_val_i;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 1; i <= NUM_STAGES; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Occupancy is a popcount of the valid bits only, so it has no input dependency.
  always_comb begin
    occupancy_o = '0;
    for (int i = 1; i <= NUM_STAGES; i++) begin
      occupancy_o = occupancy_o + CNT_W'(vld_q[i]);
    end
  end

  assign out_valid_o = vld_q[NUM_STAGES];
  assign out_data_o  = dat_q[NUM_STAGES];
  assign empty_o     = (occupancy_o == '0);
  assign full_o      = (occupancy_o == CNT_W'(NUM_STAGES));

endmodule

// File: tb/tb_riscv_v_elastic_stage.sv
// Bench for riscv_v_elastic_stage: a 3-stage instance checked cycle by cycle against a
// queue-of-entries model, plus a 1-stage instance checked with an in-order scoreboard.
module tb_riscv_v_elastic_stage;

  localparam int          NS     = 3;
  localparam logic [8:0]  RstVal = 9'h1A5;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] rst_val;
  logic       flush;

  // 3-stage instance.
  logic       in_valid, in_ready, out_valid, out_ready, empty, full;
  logic [8:0] in_data, out_data;
  logic [1:0] occupancy;

  // 1-stage instance.
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, empty_b, full_b;
  logic [8:0] in_data_b, out_data_b;
  logic [0:0] occupancy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the 3-stage pipe: entries in order, oldest first, each with a stage position.
  int         mpos[$];
  logic [8:0] mdat[$];
  logic [8:0] m_last;   // payload last delivered into the output stage
  logic       last_rdy;

  logic [8:0] sb[$];    // scoreboard for the 1-stage instance

  always #5 clk = ~clk;

  riscv_v_elastic_stage #(.DATA_W(9), .NUM_STAGES(NS)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rst_val_i  (rst_val),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .occupancy_o(occupancy),
    .empty_o    (empty),
    .full_o     (full)
  );

  riscv_v_elastic_stage #(.DATA_W(9), .NUM_STAGES(1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .rst_val_i  (rst_val),
    .flush_i    (flush),
    .in_valid_i (in_valid_b),
    .in_ready_o (in_ready_b),
    .in_data_i  (in_data_b),
    .out_valid_o(out_valid_b),
    .out_ready_i(out_ready_b),
    .out_data_o (out_data_b),
    .occupancy_o(occupancy_b),
    .empty_o    (empty_b),
    .full_o     (full_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mpos.delete();
    mdat.delete();
    m_last = RstVal;
  endtask

  // One clock edge of the model: entries advance one stage unless blocked by a
  // non-moving entry directly ahead; the head leaves from the last stage on out_ready.
  task automatic model_step(input logic acc_rdy);
    int ahead, op, np;
    if (flush) begin
      model_reset();
      return;
    end
    ahead = NS + 1;
    for (int k = 0; k < mpos.size(); k++) begin
      op = mpos[k];
      if (k == 0 && op == NS) np = out_ready ? NS + 1 : NS;
      else np = (op + 1 < ahead - 1) ? op + 1 : ahead - 1;
      if (np == NS && op != NS) m_last = mdat[k];
      mpos[k] = np;
      ahead   = np;
    end
    if (mpos.size() > 0 && mpos[0] > NS) begin
      void'(mpos.pop_front());
      void'(mdat.pop_front());
    end
    if (in_valid && acc_rdy) begin
      mpos.push_back(1);
      mdat.push_back(in_data);
    end
  endtask

  // Called at a falling edge with inputs already driven: compare, clock, update model.
  task automatic cycle_a();
    int   occ;
    logic e_vld;
    #1;
    occ      = mpos.size();
    last_rdy = !flush && !(occ == NS && !out_ready);
    e_vld    = 1'b0;
    if (occ > 0) e_vld = (mpos[0] == NS);
    check("in_ready", in_ready, last_rdy);
    check("out_valid", out_valid, e_vld);
    check("out_data", out_data, m_last);
    check("occupancy", occupancy, occ);
    check("empty", empty, occ == 0);
    check("full", full, occ == NS);
    @(posedge clk);
    model_step(last_rdy);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] bp_vals [4];
    logic [8:0] seq_b;
    int         idx, n_out_b, n_in_b;
    logic       e_b;

    rst = 1'b1; rst_val = RstVal; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle_a();

    // Streaming, back-to-back with the sink always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 9'(i);
      cycle_a();
    end
    in_valid = 1'b0;
    repeat (4) cycle_a();

    // Back-pressure fill: only three of four fit.
    bp_vals = '{9'h010, 9'h011, 9'h012, 9'h013};
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = bp_vals[idx];
      cycle_a();
      if (last_rdy && idx < 3) idx++;
    end
    #1;
    check("bp_accepted", idx, 3);
    check("bp_occupancy", occupancy, 3);
    check("bp_full", full, 1);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out", out_data, 9'h010);
    cycle_a();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check("bp_release_occ", occupancy, 3);
    out_ready = 1'b1;
    repeat (5) cycle_a();

    // Bubble collapse under a stalled sink.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 9'h020; cycle_a();
    in_valid = 1'b0; repeat (2) cycle_a();
    in_valid = 1'b1; in_data = 9'h021; cycle_a();
    in_valid = 1'b0; cycle_a();
    #1;
    check("bubble_occupancy", occupancy, 2);
    check("bubble_head", out_data, 9'h020);
    out_ready = 1'b1;
    repeat (4) cycle_a();

    // Flush a full pipe while the source offers another entry.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 9'h030 + 9'(i);
      cycle_a();
    end
    flush = 1'b1; in_data = 9'h033;
    #1;
    check("flush_in_ready", in_ready, 0);
    cycle_a();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_occupancy", occupancy, 0);
    check("flush_out_data", out_data, RstVal);
    out_ready = 1'b1;
    repeat (4) cycle_a();

    // 1-stage instance: continuous source, sink alternating ready.
    seq_b = 9'h100; n_out_b = 0; n_in_b = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready_b = (i % 2 == 0);
      in_valid_b  = 1'b1;
      in_data_b   = seq_b;
      #1;
      e_b = !(sb.size() == 1 && !out_ready_b);
      check("b_in_ready", in_ready_b, e_b);
      check("b_out_valid", out_valid_b, sb.size() == 1);
      if (sb.size() > 0) check("b_out_data", out_data_b, sb[0]);
      if (sb.size() == 1 && out_ready_b) begin
        void'(sb.pop_front());
        n_out_b++;
      end
      if (e_b) begin
        sb.push_back(seq_b);
        seq_b++;
        n_in_b++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid_b = 1'b0;
    #1;
    check("b_delivered", n_out_b, 19);
    check("b_conserved", n_in_b - n_out_b, occupancy_b);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 9'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      cycle_a();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a cycle with entries in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      in_data = 9'($urandom);
      cycle_a();
    end
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, RstVal);
    check("rst_occupancy", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_b_out_valid", out_valid_b, 0);
    model_reset();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) cycle_a();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_v_elastic_stage.md
Name: riscv_v_elastic_stage

Overview:
- Parametrised successor to the fixed enable/flush delay line used between RISC-V V pipeline stages.
- Multi-stage elastic register pipeline carrying a DATA_W payload with valid/ready flow control.
- Provides per-stage bubble collapsing, synchronous flush and occupancy reporting.
- Sits between decode/issue/execute boundaries where downstream stalls must back-pressure upstream without losing or duplicating data.

Parameters:
- DATA_W, 9, payload width in bits (>=1).
- NUM_STAGES, 2, number of register stages (1..16). Values outside this range are an elaboration error.
- CNT_W, $clog2(NUM_STAGES+1), width of the occupancy output (derived, not overridden).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rst_val  input  DATA_W  value loaded into every stage data register on reset and on flush.
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  block accepts data this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage NUM_STAGES holds valid data.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload of stage NUM_STAGES.
- occupancy  output  CNT_W  number of valid stages.
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == NUM_STAGES.

Behaviour:
- State per stage i (1..NUM_STAGES): vld[i], dat[i]. Stage 0 is the input port (vld[0]=in_valid, dat[0]=in_data).
- Reset (async, rst=1): all vld=0 and all dat=rst_val.
  - Resulting outputs: out_valid=0, out_data=rst_val, occupancy=0, empty=1, full=0, in_ready=0 while rst is asserted.
- Ready chain (combinational): rdy[NUM_STAGES+1]=out_ready; rdy[i] = !vld[i] || rdy[i+1]; in_ready = rdy[1] && !flush && !rst.
- Stage advance: stage i loads on the edge when rdy[i]=1.
  - vld[i] <= vld[i-1] (for i=1, vld[0] gated by in_ready).
  - dat[i] <= dat[i-1] only when vld[i-1]=1. Otherwise dat[i] holds, so bubbles never overwrite data with garbage.
  - When rdy[i]=0, stage i holds both vld and dat.
- Bubble collapse: an invalid stage always accepts from its predecessor even when downstream is stalled. With out_ready=0, the pipe fills to NUM_STAGES entries before in_ready drops.
- Latency: on an empty pipe with out_ready=1, data accepted at edge k appears on out_data/out_valid after edge k+NUM_STAGES-1.
  - Equivalent statement: NUM_STAGES register edges from the input sample point.
  - Throughput is one transfer per cycle when out_ready=1 continuously.
- Transfer definitions: input handshake = in_valid && in_ready; output handshake = out_valid && out_ready. Data order is strictly preserved; no drops, no duplicates.
- Flush (synchronous, priority over advance):
  - On the edge with flush=1, all vld<=0 and all dat<=rst_val.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - out_valid still reflects the current vld[NUM_STAGES]. A downstream handshake in the flush cycle counts as a transfer, and the entry is then cleared.
- Reset priority: rst > flush > advance. Reset mid-transfer discards all entries immediately.
- occupancy: popcount of vld[1..NUM_STAGES], registered-state derived, no input dependency. empty and full are decoded from occupancy.
- Simultaneous accept and drain when full with out_ready=1: the whole pipe shifts, in_ready=1, and occupancy stays NUM_STAGES.
- Combinational paths allowed: out_ready->in_ready and flush->in_ready. No other input-to-output combinational path.

Test Plan:
- Reset: DATA_W=9, NUM_STAGES=3, rst_val=0x1A5, rst pulsed asynchronously mid-cycle -> out_valid=0, out_data=0x1A5, occupancy=0, empty=1 immediately, without waiting for clk.
- Streaming: out_ready=1, send 0x001..0x00A back-to-back -> 0x001 on out_data 3 edges after acceptance, then one value per cycle in order, in_ready held 1.
- Back-pressure fill: out_ready=0, send 0x010,0x011,0x012,0x013 -> first three accepted, occupancy=3, full=1, in_ready=0, 0x013 held upstream.
  - Then raise out_ready for 1 cycle -> 0x010 transfers, 0x013 accepted the same edge, occupancy remains 3.
- Bubble collapse: send 0x020, idle 2 cycles, send 0x021 with out_ready=0 -> both packed in stages 3 and 2, occupancy=2, no duplicate on release.
- Flush: pipe full (0x030..0x032), assert flush 1 cycle with in_valid=1 and in_data=0x033 -> in_ready=0 that cycle, next cycle occupancy=0, out_data=rst_val, and 0x033 is never output.
- NUM_STAGES=1 variant: alternating out_ready 1/0 with continuous input -> output sequence matches input order exactly, with no losses.
